// File: rtl/spike_scheduler.sv
// rtl/spike_scheduler.sv - time-stamped spike event scheduler feeding nn row lines
module spike_scheduler #(
    parameter int NUM_SYNAPSE_ROWS = 2,
    parameter int TIME_WIDTH       = 16,
    parameter int DEPTH            = 8,
    parameter int ROW_W            = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        clear_time,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic [TIME_WIDTH-1:0]       ev_time,
    input  logic [ROW_W-1:0]            ev_row,
    output logic [NUM_SYNAPSE_ROWS-1:0] spike_out,
    output logic [TIME_WIDTH-1:0]       now,
    output logic [$clog2(DEPTH):0]      pending,
    output logic                        err_order,
    output logic                        err_row,
    output logic                        err_late
);

    localparam int AW = $clog2(DEPTH);

    // Event storage; pointers carry one extra wrap bit so full and empty differ.
    logic [TIME_WIDTH-1:0]       r_mem_time [DEPTH];
    logic [ROW_W-1:0]            r_mem_row  [DEPTH];
    logic [AW:0]                 r_wr_ptr;
    logic [AW:0]                 r_rd_ptr;
    logic [TIME_WIDTH-1:0]       r_now;
    logic [TIME_WIDTH-1:0]       r_last_time;
    logic [NUM_SYNAPSE_ROWS-1:0] r_spike;
    logic                        r_err_order;
    logic                        r_err_row;
    logic                        r_err_late;

    logic [AW:0]                 w_count;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_accept;
    logic                        w_row_bad;
    logic                        w_order_bad;
    logic                        w_push;
    logic                        w_due;
    logic [TIME_WIDTH-1:0]       w_head_time;
    logic [ROW_W-1:0]            w_head_row;
    logic [NUM_SYNAPSE_ROWS-1:0] w_onehot;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == (AW+1)'(DEPTH));
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign ev_ready    = !w_full && !clear_time;
    assign w_accept    = ev_valid && ev_ready;

    // A row index can only be out of range when its field can encode more rows than exist.
    generate
        if ((1 << ROW_W) > NUM_SYNAPSE_ROWS) begin : g_row_chk
            assign w_row_bad = (ev_row >= ROW_W'(NUM_SYNAPSE_ROWS));
        end else begin : g_row_nochk
            assign w_row_bad = 1'b0;
        end
    endgenerate

    // Row errors take priority: a bad-row event never reaches the ordering check.
    assign w_order_bad = !w_row_bad && (ev_time < r_last_time);
    assign w_push      = w_accept && !w_row_bad && !w_order_bad;

    assign w_head_time = r_mem_time[r_rd_ptr[AW-1:0]];
    assign w_head_row  = r_mem_row[r_rd_ptr[AW-1:0]];
    assign w_due       = enable && !w_empty && (w_head_time <= r_now);

    // Decode the head row into the one-hot release pattern.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_SYNAPSE_ROWS; i++) begin
            if (w_head_row == ROW_W'(i)) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Event payload write; contents are don't-care until the write pointer covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_time[r_wr_ptr[AW-1:0]] <= ev_time;
            r_mem_row[r_wr_ptr[AW-1:0]]  <= ev_row;
        end
    end

    // Pointers, time counter, release pulse and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_now       <= '0;
            r_last_time <= '0;
            r_spike     <= '0;
            r_err_order <= 1'b0;
            r_err_row   <= 1'b0;
            r_err_late  <= 1'b0;
        end else if (clear_time) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_now       <= '0;
            r_last_time <= '0;
            r_spike     <= '0;
            r_err_order <= 1'b0;
            r_err_row   <= 1'b0;
            r_err_late  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + (AW+1)'(1);
                r_last_time <= ev_time;
            end
            if (w_accept && w_row_bad) begin
                r_err_row <= 1'b1;
            end
            if (w_accept && w_order_bad) begin
                r_err_order <= 1'b1;
            end
            // Time freezes while a due event drains so same-timestamp events serialise.
            if (w_due) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                r_spike  <= w_onehot;
                if (w_head_time < r_now) begin
                    r_err_late <= 1'b1;
                end
            end else begin
                r_spike <= '0;
                if (enable) begin
                    r_now <= r_now + TIME_WIDTH'(1);
                end
            end
        end
    end

    assign spike_out = r_spike;
    assign now       = r_now;
    assign pending   = w_count;
    assign err_order = r_err_order;
    assign err_row   = r_err_row;
    assign err_late  = r_err_late;

endmodule

// File: tb/tb_spike_scheduler.sv
// tb/tb_spike_scheduler.sv - scoreboard bench for spike_scheduler
module tb_spike_scheduler;

    localparam int N  = 2;
    localparam int TW = 16;
    localparam int D  = 8;
    localparam int RW = 2;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          clear_time;
    logic          ev_valid;
    logic          ev_ready;
    logic [TW-1:0] ev_time;
    logic [RW-1:0] ev_row;
    logic [N-1:0]  spike_out;
    logic [TW-1:0] now;
    logic [3:0]    pending;
    logic          err_order;
    logic          err_row;
    logic          err_late;

    typedef struct {
        logic [N-1:0]  spk;
        logic [TW-1:0] t;
    } exp_t;

    exp_t sbq[$];
    int   total;
    int   bad;
    logic mon_en;

    spike_scheduler #(
        .NUM_SYNAPSE_ROWS(N),
        .TIME_WIDTH(TW),
        .DEPTH(D),
        .ROW_W(RW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .clear_time(clear_time),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_time(ev_time),
        .ev_row(ev_row),
        .spike_out(spike_out),
        .now(now),
        .pending(pending),
        .err_order(err_order),
        .err_row(err_row),
        .err_late(err_late)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Release monitor: every pulse must match the oldest expected release.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && spike_out !== '0) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL stray_pulse spike_out=%b now=%0d expected no pulse", spike_out, now);
            end else begin
                e = sbq.pop_front();
                if (spike_out !== e.spk || now !== e.t) begin
                    bad++;
                    $display("FAIL release got spike=%b now=%0d expected spike=%b now=%0d",
                             spike_out, now, e.spk, e.t);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [TW-1:0] t, input logic [RW-1:0] r);
        ev_valid = 1'b1;
        ev_time  = t;
        ev_row   = r;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
    endtask

    task automatic expect_ev(input logic [TW-1:0] t, input logic [RW-1:0] r, input logic [TW-1:0] at);
        exp_t e;
        e.spk = N'(1) << r;
        e.t   = at;
        sbq.push_back(e);
        send(t, r);
    endtask

    task automatic do_clear();
        clear_time = 1'b1;
        step(1);
        clear_time = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int cnt = 0;
        while (sbq.size() != 0 && cnt < budget) begin
            step(1);
            cnt++;
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout remaining=%0d expected 0", name, sbq.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(2);
        total++;
        if (spike_out !== '0 || now !== '0 || pending !== '0) begin
            bad++;
            $display("FAIL reset_state spike=%b now=%0d pending=%0d expected 0/0/0", spike_out, now, pending);
        end
        total++;
        if ({err_order, err_row, err_late} !== 3'b000) begin
            bad++;
            $display("FAIL reset_errs got=%b expected 000", {err_order, err_row, err_late});
        end
        reset = 1'b1;
        step(1);
        total++;
        if (ev_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b expected 1", ev_ready);
        end
    endtask

    task automatic test_ordered();
        enable = 1'b0;
        expect_ev(50, 0, 50);
        expect_ev(60, 1, 60);
        expect_ev(100, 0, 100);
        total++;
        if (pending !== 4'd3) begin
            bad++;
            $display("FAIL ordered_pending got=%0d expected 3", pending);
        end
        enable = 1'b1;
        drain("ordered", 300);
        step(1);
        enable = 1'b0;
        total++;
        if ({err_order, err_row, err_late} !== 3'b000 || pending !== 4'd0) begin
            bad++;
            $display("FAIL ordered_errs errs=%b pending=%0d expected 000/0", {err_order, err_row, err_late}, pending);
        end
    endtask

    task automatic test_same_time();
        do_clear();
        expect_ev(20, 0, 20);
        expect_ev(20, 1, 20);
        expect_ev(20, 0, 20);
        enable = 1'b1;
        drain("same_time", 100);
        total++;
        if (now !== 16'd21) begin
            bad++;
            $display("FAIL same_time_resume now=%0d expected 21", now);
        end
        enable = 1'b0;
    endtask

    task automatic test_full();
        int cnt = 0;
        do_clear();
        for (int i = 1; i <= D; i++) begin
            expect_ev(TW'(i), RW'(i % 2), TW'(i));
        end
        total++;
        if (ev_ready !== 1'b0 || pending !== 4'd8) begin
            bad++;
            $display("FAIL full_state ready=%b pending=%0d expected 0/8", ev_ready, pending);
        end
        enable = 1'b1;
        while (spike_out === '0 && cnt < 50) begin
            step(1);
            cnt++;
        end
        total++;
        if (ev_ready !== 1'b1 || pending !== 4'd7) begin
            bad++;
            $display("FAIL full_first_pop ready=%b pending=%0d expected 1/7", ev_ready, pending);
        end
        drain("full", 100);
        enable = 1'b0;
    endtask

    task automatic test_errors();
        do_clear();
        send(10, 0);
        send(5, 1);
        total++;
        if (pending !== 4'd1 || err_order !== 1'b1 || err_row !== 1'b0) begin
            bad++;
            $display("FAIL order_drop pending=%0d err_order=%b err_row=%b expected 1/1/0", pending, err_order, err_row);
        end
        send(20, 2);
        total++;
        if (pending !== 4'd1 || err_row !== 1'b1) begin
            bad++;
            $display("FAIL row_drop pending=%0d err_row=%b expected 1/1", pending, err_row);
        end
        do_clear();
        send(10, 0);
        send(3, 3);
        total++;
        if (err_row !== 1'b1 || err_order !== 1'b0) begin
            bad++;
            $display("FAIL row_priority err_row=%b err_order=%b expected 1/0", err_row, err_order);
        end
        send(10, 1);
        total++;
        if (pending !== 4'd2 || err_order !== 1'b0) begin
            bad++;
            $display("FAIL equal_time_accept pending=%0d err_order=%b expected 2/0", pending, err_order);
        end
        do_clear();
        total++;
        if (pending !== 4'd0 || {err_order, err_row, err_late} !== 3'b000 || now !== '0) begin
            bad++;
            $display("FAIL errors_cleared pending=%0d errs=%b now=%0d expected 0/000/0",
                     pending, {err_order, err_row, err_late}, now);
        end
    endtask

    task automatic test_late();
        int cnt = 0;
        do_clear();
        enable = 1'b1;
        while (now !== 16'd40 && cnt < 100) begin
            step(1);
            cnt++;
        end
        total++;
        if (now !== 16'd40) begin
            bad++;
            $display("FAIL late_reach_40 now=%0d expected 40", now);
        end
        expect_ev(3, 1, 41);
        drain("late", 10);
        step(1);
        total++;
        if (err_late !== 1'b1 || err_order !== 1'b0) begin
            bad++;
            $display("FAIL late_flag err_late=%b err_order=%b expected 1/0", err_late, err_order);
        end
        enable = 1'b0;
    endtask

    task automatic test_clear_reset();
        exp_t e;
        int   cnt = 0;
        do_clear();
        for (int i = 0; i < 4; i++) begin
            send(TW'(100 + i), RW'(i % 2));
        end
        total++;
        if (pending !== 4'd4) begin
            bad++;
            $display("FAIL clear_prefill pending=%0d expected 4", pending);
        end
        enable = 1'b1;
        ev_valid = 1'b1;
        ev_time = 16'd200;
        ev_row = 2'd0;
        do_clear();
        ev_valid = 1'b0;
        total++;
        if (pending !== 4'd0 || now !== '0 || spike_out !== '0 || {err_order, err_row, err_late} !== 3'b000) begin
            bad++;
            $display("FAIL clear_state pending=%0d now=%0d spike=%b errs=%b expected 0/0/0/000",
                     pending, now, spike_out, {err_order, err_row, err_late});
        end
        enable = 1'b0;
        send(2, 1);
        send(2, 0);
        enable = 1'b1;
        mon_en = 1'b0;
        while (spike_out === '0 && cnt < 50) begin
            step(1);
            cnt++;
        end
        total++;
        if (spike_out !== 2'b10 || now !== 16'd2) begin
            bad++;
            $display("FAIL reset_pre_pulse spike=%b now=%0d expected 10/2", spike_out, now);
        end
        reset = 1'b0;
        #1;
        total++;
        if (spike_out !== '0 || now !== '0 || pending !== '0) begin
            bad++;
            $display("FAIL reset_abort spike=%b now=%0d pending=%0d expected 0/0/0", spike_out, now, pending);
        end
        mon_en = 1'b1;
        step(2);
        reset = 1'b1;
        step(12);
        total++;
        if (pending !== '0 || {err_order, err_row, err_late} !== 3'b000) begin
            bad++;
            $display("FAIL reset_after pending=%0d errs=%b expected 0/000", pending, {err_order, err_row, err_late});
        end
        enable = 1'b0;
        e.spk = '0;
        e.t   = '0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        mon_en     = 1'b0;
        reset      = 1'b0;
        enable     = 1'b0;
        clear_time = 1'b0;
        ev_valid   = 1'b0;
        ev_time    = '0;
        ev_row     = '0;
        test_reset();
        mon_en = 1'b1;
        test_ordered();
        test_same_time();
        test_full();
        test_errors();
        test_late();
        test_clear_reset();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover remaining=%0d expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spike_scheduler.md
# spike_scheduler

Time-stamped spike event scheduler sitting between the host/testbench event source and the `spike_in` row lines of `nn`. Accepts events (timestamp, row) into an in-order FIFO, runs a local time counter, and releases each event as a one-cycle pulse on its row line when the counter reaches the event's timestamp. Holds time while due events drain, so simultaneous events are serialised without loss. Reports ordering, lateness and row-range errors via sticky flags.

## Interface
- `NUM_SYNAPSE_ROWS`, 2, number of spike row lines driven
- `TIME_WIDTH`, 16, width of timestamps and time counter
- `DEPTH`, 8, event FIFO depth (power of two, ≥2)
- `ROW_W`, $clog2(NUM_SYNAPSE_ROWS) (min 1), row index width (derived localparam)

Ports:
- `clk`  in  1  main clock
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  run: time advances and events may release
- `clear_time`  in  1  synchronous: now←0, flush FIFO, clear errors
- `ev_valid`  in  1  event offered
- `ev_ready`  out  1  event accepted at edge when `ev_valid && ev_ready`
- `ev_time`  in  TIME_WIDTH  event release time
- `ev_row`  in  ROW_W  target row
- `spike_out`  out  NUM_SYNAPSE_ROWS  one-hot release pulses, registered
- `now`  out  TIME_WIDTH  current time counter
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy
- `err_order`  out  1  sticky: event with time < last accepted time
- `err_row`  out  1  sticky: event with row ≥ NUM_SYNAPSE_ROWS
- `err_late`  out  1  sticky: event released with head time < now

## Operation
- Reset values: `spike_out`=0, `now`=0, `pending`=0, all err=0, last_time=0; `ev_ready`=1 once reset deasserts.
- `ev_ready` = !full && !clear_time (combinational).
- Accept: event checked at accept edge. Row out of range → dropped, `err_row` set. Time < last_time → dropped, `err_order` set. Otherwise written to FIFO, last_time←ev_time. Row check has priority (row-bad event neither updates last_time nor sets `err_order`).
- due = enable && !empty && head_time ≤ now (unsigned, on registered state).
- Each edge: if due → pop head, `spike_out` ← one-hot(head_row), `now` holds; set `err_late` if head_time < now. Else `spike_out`←0, `now`←now+1 if enable, else hold.
- At most one release per cycle; events sharing a timestamp release in consecutive cycles with `now` frozen.
- `now` wraps 2^TIME_WIDTH−1 → 0; no wrap-aware comparison; driver uses `clear_time` before wrap.
- `enable`=0: no pops, no increment, `spike_out`=0 next cycle; accepts continue.
- `clear_time`: next edge now=0, FIFO empty, last_time=0, errs=0, `spike_out`=0; overrides pop and accept.
- Simultaneous push and pop in one cycle allowed, including when full (ready still low when full; no push-through). Pushed event not visible at head until next cycle (no bypass).
- Reset mid-operation: all state to reset values immediately, in-flight pulse aborted.

## Timing
- Accept→earliest release: event accepted at edge k with time ≤ now can pop at edge k+1; pulse visible cycle after k+1.
- Pulse width exactly 1 cycle per event; back-to-back same-row events give consecutive-cycle pulses.
- `pending` updates at the edge: +1 push, −1 pop, unchanged if both.
- Error flags assert cycle after the offending edge, cleared only by reset or `clear_time`.

## Test plan
- Ordered events (50,r0),(60,r1),(100,r0), enable at now=0 → `spike_out`=01 after edge where now=50, 10 at now=60, 01 at now=100; no errors.
- Three events at time 20 rows 0,1,0 → pulses on three consecutive cycles, `now` held at 20 for two extra cycles, then resumes at 21.
- Fill DEPTH events with enable=0 → `ev_ready`=0, `pending`=DEPTH; enable → pops restore ready after first release.
- Event time 5 after event time 10 → dropped, `err_order`=1, `pending` unchanged; row=2 with NUM_SYNAPSE_ROWS=2 → dropped, `err_row`=1.
- Event time 3 pushed at now=40 → released next cycle, `err_late`=1.
- Assert `clear_time` with 4 pending and `reset` pulse mid-release → FIFO empty, now=0, errors 0, `spike_out`=0, no stray pulse.
